// File: rtl/nt_controller.sv
// HDR-DDR normal-transfer controller: drives the shared serializer and
// deserializer through the command, data and CRC phases of a private
// read or write, moving data bytes to and from the register file.
module nt_controller #(
    parameter logic [9:0] START_ADDR = 10'd1000,
    parameter logic [9:0] CMD_ADDR   = 10'd998
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_engine_en,
    input  logic       i_rnw,
    input  logic [7:0] i_word_cnt,
    input  logic       i_tx_mode_done,
    input  logic       i_rx_mode_done,
    input  logic       i_rx_pre,
    input  logic       i_rx_error,
    output logic       o_tx_en,
    output logic [2:0] o_tx_mode,
    output logic       o_rx_en,
    output logic [3:0] o_rx_mode,
    output logic       o_sdahand_pp_od,
    output logic       o_regf_rd_en,
    output logic       o_regf_wr_en,
    output logic [9:0] o_regf_addr,
    output logic       o_bitcnt_en,
    output logic       o_bitcnt_reset,
    output logic       o_engine_done,
    output logic [1:0] o_engine_err
);
    localparam logic [2:0] TX_PRE0 = 3'b000, TX_PRE1 = 3'b001, TX_BYTE = 3'b011,
                           TX_TOK  = 3'b010, TX_PAR  = 3'b110, TX_CRC  = 3'b111;
    localparam logic [3:0] RX_PRE = 4'b0001, RX_DATA = 4'b0010, RX_PAR = 4'b0100,
                           RX_TOK = 4'b0101, RX_CRC  = 4'b0110;

    typedef enum logic [4:0] {
        S_IDLE, S_CMD_P1, S_CMD_P2, S_CMD_B1, S_CMD_B2, S_CMD_PAR,
        S_WR_P1, S_WR_P2, S_WR_B1, S_WR_B2, S_WR_PAR,
        S_RD_P1, S_RD_ACK, S_RD_B1, S_RD_B2, S_RD_PAR, S_RD_NP1, S_RD_ABT,
        S_CRC_RX_P2, S_CRC_RX_TOK, S_CRC_RX_VAL,
        S_CRC_P1, S_CRC_P2, S_CRC_TOK, S_CRC_VAL, S_FIN
    } state_t;

    state_t     r_state, w_next;
    logic       r_rnw;
    logic [7:0] r_cnt;
    logic [9:0] r_ptr;
    logic [1:0] r_err;
    logic       w_md, w_start, w_err_ld, w_cnt_dec, w_ptr_inc;
    logic [1:0] w_err_val;
    logic [7:0] w_cnt_m1;

    // Either engine finishing its mode is one handshake; both at once count once.
    assign w_md     = i_tx_mode_done | i_rx_mode_done;
    assign w_cnt_m1 = (r_cnt == 8'd0) ? 8'd0 : r_cnt - 8'd1;

    // State register; reset aborts any transfer straight back to IDLE.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Transfer context: direction, remaining words, data pointer, status.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            r_rnw <= 1'b0;
            r_cnt <= 8'd0;
            r_ptr <= START_ADDR;
            r_err <= 2'b00;
        end else if (w_start) begin
            r_rnw <= i_rnw;
            // a zero-length read still moves one word
            r_cnt <= (i_rnw && i_word_cnt == 8'd0) ? 8'd1 : i_word_cnt;
            r_ptr <= START_ADDR;
            r_err <= 2'b00;
        end else begin
            if (r_state == S_FIN) r_cnt <= 8'd0;
            else if (w_cnt_dec)   r_cnt <= w_cnt_m1;
            if (w_ptr_inc) r_ptr <= r_ptr + 10'd1;
            if (w_err_ld)  r_err <= w_err_val;
        end
    end

    // Next state: every working state waits for a handshake before moving on.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_err_ld  = 1'b0;
        w_err_val = 2'b00;
        w_cnt_dec = 1'b0;
        w_ptr_inc = 1'b0;
        case (r_state)
            S_IDLE: if (i_engine_en) begin w_next = S_CMD_P1; w_start = 1'b1; end
            S_FIN:  w_next = S_IDLE;
            default: if (w_md) begin
                case (r_state)
                    S_CMD_P1:  w_next = S_CMD_P2;
                    S_CMD_P2:  w_next = S_CMD_B1;
                    S_CMD_B1:  w_next = S_CMD_B2;
                    S_CMD_B2:  w_next = S_CMD_PAR;
                    S_CMD_PAR: w_next = r_rnw ? S_RD_P1 : ((r_cnt != 8'd0) ? S_WR_P1 : S_CRC_P1);
                    S_WR_P1:   w_next = S_WR_P2;
                    S_WR_P2:   if (i_rx_pre) w_next = S_WR_B1;
                               else begin w_next = S_FIN; w_err_ld = 1'b1; w_err_val = 2'b11; end
                    S_WR_B1:   begin w_next = S_WR_B2; w_ptr_inc = 1'b1; end
                    S_WR_B2:   begin w_next = S_WR_PAR; w_ptr_inc = 1'b1; end
                    S_WR_PAR:  begin w_cnt_dec = 1'b1; w_next = (w_cnt_m1 != 8'd0) ? S_WR_P1 : S_CRC_P1; end
                    S_RD_P1:   w_next = S_RD_ACK;
                    S_RD_ACK:  if (!i_rx_pre) w_next = S_RD_B1;
                               else begin w_next = S_FIN; w_err_ld = 1'b1; w_err_val = 2'b01; end
                    S_RD_B1:   begin w_next = S_RD_B2; w_ptr_inc = 1'b1; end
                    S_RD_B2:   begin w_next = S_RD_PAR; w_ptr_inc = 1'b1; end
                    S_RD_PAR:  if (i_rx_error) begin w_next = S_FIN; w_err_ld = 1'b1; w_err_val = 2'b10; end
                               else begin w_next = S_RD_NP1; w_cnt_dec = 1'b1; end
                    // target preamble 1 means it wants to send another word
                    S_RD_NP1:  w_next = i_rx_pre ? S_RD_ABT : S_CRC_RX_P2;
                    S_RD_ABT:  w_next = (r_cnt != 8'd0) ? S_RD_B1 : S_FIN;
                    S_CRC_RX_P2, S_CRC_RX_TOK, S_CRC_RX_VAL:
                        if (i_rx_error) begin w_next = S_FIN; w_err_ld = 1'b1; w_err_val = 2'b10; end
                        else if (r_state == S_CRC_RX_P2)  w_next = S_CRC_RX_TOK;
                        else if (r_state == S_CRC_RX_TOK) w_next = S_CRC_RX_VAL;
                        else                              w_next = S_FIN;
                    S_CRC_P1:  w_next = S_CRC_P2;
                    S_CRC_P2:  w_next = S_CRC_TOK;
                    S_CRC_TOK: w_next = S_CRC_VAL;
                    S_CRC_VAL: w_next = S_FIN;
                    default:   w_next = S_IDLE;
                endcase
            end
        endcase
    end

    // Output decode from the current state; read-data strobe rides the handshake.
    always_comb begin
        o_tx_en        = 1'b0;
        o_tx_mode      = TX_PRE0;
        o_rx_en        = 1'b0;
        o_rx_mode      = RX_PRE;
        o_regf_rd_en   = 1'b0;
        o_regf_wr_en   = 1'b0;
        o_regf_addr    = r_ptr;
        o_bitcnt_en    = (r_state != S_IDLE);
        o_bitcnt_reset = 1'b0;
        o_engine_done  = 1'b0;
        case (r_state)
            S_IDLE:       begin o_regf_addr = START_ADDR; o_bitcnt_reset = 1'b1; end
            S_CMD_P1:     begin o_tx_en = 1'b1; o_tx_mode = TX_PRE0; end
            S_CMD_P2:     begin o_tx_en = 1'b1; o_tx_mode = TX_PRE1; end
            S_CMD_B1:     begin o_tx_en = 1'b1; o_tx_mode = TX_BYTE; o_regf_rd_en = 1'b1; o_regf_addr = CMD_ADDR; end
            S_CMD_B2:     begin o_tx_en = 1'b1; o_tx_mode = TX_BYTE; o_regf_rd_en = 1'b1; o_regf_addr = CMD_ADDR + 10'd1; end
            S_CMD_PAR:    begin o_tx_en = 1'b1; o_tx_mode = TX_PAR; end
            S_WR_P1:      begin o_tx_en = 1'b1; o_tx_mode = TX_PRE1; end
            S_WR_P2:      begin o_rx_en = 1'b1; o_rx_mode = RX_PRE; end
            S_WR_B1, S_WR_B2: begin o_tx_en = 1'b1; o_tx_mode = TX_BYTE; o_regf_rd_en = 1'b1; end
            S_WR_PAR:     begin o_tx_en = 1'b1; o_tx_mode = TX_PAR; end
            S_RD_P1:      begin o_tx_en = 1'b1; o_tx_mode = TX_PRE1; end
            S_RD_ACK:     begin o_rx_en = 1'b1; o_rx_mode = RX_PRE; end
            S_RD_B1, S_RD_B2: begin o_rx_en = 1'b1; o_rx_mode = RX_DATA; o_regf_wr_en = w_md; end
            S_RD_PAR:     begin o_rx_en = 1'b1; o_rx_mode = RX_PAR; end
            S_RD_NP1:     begin o_rx_en = 1'b1; o_rx_mode = RX_PRE; end
            S_RD_ABT:     begin o_tx_en = 1'b1; o_tx_mode = (r_cnt != 8'd0) ? TX_PRE1 : TX_PRE0; end
            S_CRC_RX_P2:  begin o_rx_en = 1'b1; o_rx_mode = RX_PRE; end
            S_CRC_RX_TOK: begin o_rx_en = 1'b1; o_rx_mode = RX_TOK; end
            S_CRC_RX_VAL: begin o_rx_en = 1'b1; o_rx_mode = RX_CRC; end
            S_CRC_P1:     begin o_tx_en = 1'b1; o_tx_mode = TX_PRE0; o_bitcnt_reset = 1'b1; end
            S_CRC_P2:     begin o_tx_en = 1'b1; o_tx_mode = TX_PRE1; end
            S_CRC_TOK:    begin o_tx_en = 1'b1; o_tx_mode = TX_TOK; end
            S_CRC_VAL:    begin o_tx_en = 1'b1; o_tx_mode = TX_CRC; end
            S_FIN:        o_engine_done = 1'b1;
            default:      ;
        endcase
    end

    assign o_sdahand_pp_od = o_tx_en;
    assign o_engine_err    = r_err;
endmodule

// File: tb/tb_nt_controller.sv
// Bench for nt_controller: a phase-list model of each transfer drives the
// handshakes and one negedge process checks every output every cycle.
module tb_nt_controller;
    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, rnw = 1'b0;
    logic [7:0] wc = 8'd0;
    logic       txd = 1'b0, rxd = 1'b0, pre = 1'b0, rerr = 1'b0;
    logic       tx_en, rx_en, sda, rd_en, wr_en, bc_en, bc_rst, done;
    logic [2:0] tx_mode;
    logic [3:0] rx_mode;
    logic [9:0] addr;
    logic [1:0] err;

    nt_controller dut (
        .i_sys_clk(clk), .i_sys_rst(rst_n), .i_engine_en(en), .i_rnw(rnw),
        .i_word_cnt(wc), .i_tx_mode_done(txd), .i_rx_mode_done(rxd),
        .i_rx_pre(pre), .i_rx_error(rerr),
        .o_tx_en(tx_en), .o_tx_mode(tx_mode), .o_rx_en(rx_en), .o_rx_mode(rx_mode),
        .o_sdahand_pp_od(sda), .o_regf_rd_en(rd_en), .o_regf_wr_en(wr_en),
        .o_regf_addr(addr), .o_bitcnt_en(bc_en), .o_bitcnt_reset(bc_rst),
        .o_engine_done(done), .o_engine_err(err)
    );

    always #5 clk = ~clk;

    // One protocol phase: what the controller must drive, and how the bench answers.
    typedef struct packed {
        logic       tx;  logic [2:0] txm;
        logic       rx;  logic [3:0] rxm;
        logic       rd;  logic       wr;  logic [9:0] addr;
        logic       pre; logic       rerr; logic      brst;
    } ph_t;

    ph_t        q[$];
    ph_t        cur;
    bit         cur_md = 0;
    int         cur_mode = 0;       // 0 idle, 1 in phase list, 2 done cycle
    logic [1:0] exp_err = 2'b00, idle_err = 2'b00;
    bit         en_noise = 0;
    int         tests = 0, fails = 0;
    int         rd_log[$], wr_log[$];
    string      p_nm;
    int         p_act, p_exp;
    bit         p_req = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // The single compare process.
    always @(negedge clk) begin
        if (p_req) chk(p_nm, p_act, p_exp);
        if (rd_en && cur_md && cur_mode == 1) rd_log.push_back(int'(addr));
        if (wr_en) wr_log.push_back(int'(addr));
        case (cur_mode)
            0: begin
                chk("idle_tx_en", tx_en, 0); chk("idle_rx_en", rx_en, 0); chk("idle_sda", sda, 0);
                chk("idle_tx_mode", tx_mode, 0); chk("idle_rx_mode", rx_mode, 1);
                chk("idle_rd", rd_en, 0); chk("idle_wr", wr_en, 0); chk("idle_addr", addr, 1000);
                chk("idle_bc_en", bc_en, 0); chk("idle_bc_rst", bc_rst, 1);
                chk("idle_done", done, 0); chk("idle_err", err, idle_err);
            end
            2: begin
                chk("fin_tx_en", tx_en, 0); chk("fin_rx_en", rx_en, 0);
                chk("fin_rd", rd_en, 0); chk("fin_wr", wr_en, 0);
                chk("fin_bc_en", bc_en, 1); chk("fin_done", done, 1); chk("fin_err", err, exp_err);
            end
            default: begin
                chk("ph_tx_en", tx_en, cur.tx); chk("ph_rx_en", rx_en, cur.rx); chk("ph_sda", sda, cur.tx);
                if (cur.tx) chk("ph_tx_mode", tx_mode, cur.txm);
                if (cur.rx) chk("ph_rx_mode", rx_mode, cur.rxm);
                chk("ph_rd", rd_en, cur.rd); chk("ph_wr", wr_en, cur.wr && cur_md);
                if (cur.rd || (cur.wr && cur_md)) chk("ph_addr", addr, cur.addr);
                chk("ph_bc_en", bc_en, 1); chk("ph_bc_rst", bc_rst, cur.brst);
                chk("ph_done", done, 0); chk("ph_err", err, 0);
            end
        endcase
    end

    task automatic post(input string nm, input int a, input int e);
        p_nm = nm; p_act = a; p_exp = e; p_req = 1;
        @(negedge clk); #1 p_req = 0;
    endtask

    task automatic push_tx(input logic [2:0] m, input logic rd, input int a, input logic br);
        ph_t p; p = '0; p.tx = 1; p.txm = m; p.rd = rd; p.addr = 10'(a); p.brst = br;
        q.push_back(p);
    endtask

    task automatic push_rx(input logic [3:0] m, input logic wr, input int a, input logic pr, input logic re);
        ph_t p; p = '0; p.rx = 1; p.rxm = m; p.wr = wr; p.addr = 10'(a); p.pre = pr; p.rerr = re;
        q.push_back(p);
    endtask

    // Model: the phase list a transfer must walk, from the protocol rules.
    // ab: write word whose target preamble is 0; nk: NACK; rw: words the target offers;
    // pe: read word with parity error; ce: CRC stage (0..2) with error.
    task automatic build(input bit rd_i, input int cnt, input int ab, input bit nk,
                         input int rw, input int pe, input int ce);
        int p = 1000, rem;
        q.delete(); exp_err = 2'b00;
        push_tx(3'b000, 0, 0, 0); push_tx(3'b001, 0, 0, 0);
        push_tx(3'b011, 1, 998, 0); push_tx(3'b011, 1, 999, 0); push_tx(3'b110, 0, 0, 0);
        if (!rd_i) begin
            rem = cnt;
            for (int w = 0; rem > 0; w++) begin
                push_tx(3'b001, 0, 0, 0);
                push_rx(4'b0001, 0, 0, w != ab, 0);
                if (w == ab) begin exp_err = 2'b11; return; end
                push_tx(3'b011, 1, p, 0); p++;
                push_tx(3'b011, 1, p, 0); p++;
                push_tx(3'b110, 0, 0, 0); rem--;
            end
            push_tx(3'b000, 0, 0, 1); push_tx(3'b001, 0, 0, 0);
            push_tx(3'b010, 0, 0, 0); push_tx(3'b111, 0, 0, 0);
            return;
        end
        rem = (cnt == 0) ? 1 : cnt;
        push_tx(3'b001, 0, 0, 0);
        push_rx(4'b0001, 0, 0, nk, 0);
        if (nk) begin exp_err = 2'b01; return; end
        for (int w = 0; w < 64; w++) begin
            push_rx(4'b0010, 1, p, 0, 0); p++;
            push_rx(4'b0010, 1, p, 0, 0); p++;
            push_rx(4'b0100, 0, 0, 0, w == pe);
            if (w == pe) begin exp_err = 2'b10; return; end
            if (rem > 0) rem--;
            push_rx(4'b0001, 0, 0, w + 1 < rw, 0);
            if (w + 1 < rw) begin
                push_tx((rem != 0) ? 3'b001 : 3'b000, 0, 0, 0);
                if (rem == 0) return;
            end else begin
                push_rx(4'b0001, 0, 0, 0, ce == 0);
                if (ce == 0) begin exp_err = 2'b10; return; end
                push_rx(4'b0101, 0, 0, 0, ce == 1);
                if (ce == 1) begin exp_err = 2'b10; return; end
                push_rx(4'b0110, 0, 0, 0, ce == 2);
                if (ce == 2) exp_err = 2'b10;
                return;
            end
        end
    endtask

    task automatic start(input bit rd_i, input int cnt);
        rnw = rd_i; wc = 8'(cnt); en = 1;
        @(posedge clk); #1 en = 0; cur_mode = 1;
    endtask

    // Walk n phases, holding each for 0..2 cycles before the handshake.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cur = q[i]; cur_md = 0; en = en_noise;
            repeat (i % 3) begin @(posedge clk); #1; end
            pre = cur.pre; rerr = cur.rerr;
            if (cur.tx) txd = 1; else rxd = 1;
            if (i % 5 == 4) begin txd = 1; rxd = 1; end
            cur_md = 1;
            @(posedge clk); #1;
            txd = 0; rxd = 0; pre = 0; rerr = 0; cur_md = 0; en = 0;
        end
    endtask

    task automatic fin();
        cur_mode = 2;
        @(posedge clk); #1 idle_err = exp_err; cur_mode = 0;
        @(posedge clk); #1;
    endtask

    task automatic chk_log(input string nm, input bit is_wr, input int b, input int n, input int a0);
        int sz = is_wr ? wr_log.size() : rd_log.size();
        post({nm, "_n"}, sz - b, n);
        for (int i = 0; i < n && b + i < sz; i++)
            post({nm, "_addr"}, is_wr ? wr_log[b + i] : rd_log[b + i], a0 + i);
    endtask

    task automatic txn(input bit rd_i, input int cnt);
        start(rd_i, cnt); run(q.size()); fin();
    endtask

    int s1_tx[17] = '{0, 1, 3, 3, 6, 1, 3, 3, 6, 1, 3, 3, 6, 0, 1, 2, 7};

    initial begin
        int rb, wb, k;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // write, 2 words, target keeps accepting
        build(0, 2, -1, 0, 0, -1, -1);
        post("s1_model_len", q.size(), 19);
        k = 0;
        foreach (q[i]) if (q[i].tx) begin
            post("s1_model_txm", int'(q[i].txm), s1_tx[k < 17 ? k : 16]); k++;
        end
        post("s1_model_ntx", k, 17);
        rb = rd_log.size(); wb = wr_log.size();
        txn(0, 2);
        chk_log("s1_rd", 0, rb, 6, 998);
        chk_log("s1_wr", 1, wb, 0, 0);
        post("s1_err", int'(err), 0);

        // read, 1 word, ACK, clean CRC; start request held high mid-transfer
        build(1, 1, -1, 0, 1, -1, -1);
        wb = wr_log.size(); en_noise = 1;
        txn(1, 1);
        en_noise = 0;
        chk_log("s2_wr", 1, wb, 2, 1000);

        // read NACK
        build(1, 1, -1, 1, 0, -1, -1);
        post("s3_model_len", q.size(), 7);
        wb = wr_log.size();
        txn(1, 1);
        chk_log("s3_wr", 1, wb, 0, 0);
        post("s3_err", int'(err), 1);

        // write 3 words, target aborts at the second data preamble
        build(0, 3, 1, 0, 0, -1, -1);
        rb = rd_log.size();
        txn(0, 3);
        chk_log("s4_rd", 0, rb, 4, 998);
        post("s4_err", int'(err), 3);

        // read 1 word, target offers another -> controller ends with PRE_ZERO
        build(1, 1, -1, 0, 2, -1, -1);
        post("s5_model_last_txm", int'(q[q.size() - 1].txm), 0);
        txn(1, 1);
        post("s5_err", int'(err), 0);

        // read parity error
        build(1, 1, -1, 0, 1, 0, -1);
        txn(1, 1);
        post("s6_err", int'(err), 2);

        // read 2 words, target offers 3: one PRE_ONE continue, then PRE_ZERO
        build(1, 2, -1, 0, 3, -1, -1);
        wb = wr_log.size();
        txn(1, 2);
        chk_log("s7_wr", 1, wb, 4, 1000);

        // zero-count read behaves as one word
        build(1, 0, -1, 0, 1, -1, -1);
        wb = wr_log.size();
        txn(1, 0);
        chk_log("s8_wr", 1, wb, 2, 1000);

        // zero-count write goes straight to CRC
        build(0, 0, -1, 0, 0, -1, -1);
        post("s9_model_len", q.size(), 9);
        txn(0, 0);

        // CRC token error on read
        build(1, 1, -1, 0, 1, -1, 1);
        txn(1, 1);
        post("s10_err", int'(err), 2);

        // reset during WR_B2 of the first data word
        build(0, 2, -1, 0, 0, -1, -1);
        start(0, 2); run(8);
        cur = q[8]; cur_md = 0;
        @(posedge clk); #1;
        rst_n = 0; cur_mode = 0; idle_err = 2'b00;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1;
        @(posedge clk); #1;
        build(1, 1, -1, 0, 1, -1, -1);
        wb = wr_log.size();
        txn(1, 1);
        chk_log("s11_wr", 1, wb, 2, 1000);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/nt_controller.md
Name: nt_controller

Overview:
- Controller-side engine for HDR-DDR normal (private read/write) transfers, the initiator counterpart of the target normal-transfer engine.
- Sequences the shared serializer (tx) and deserializer (rx) through the phases of the transfer: command preamble, command word and parity, then data words with preambles and parity, then CRC preamble, token and value.
- Fetches write data from the register file and stores read data into it.
- Started by the HDR engine controller; returns a one-cycle done pulse plus a status code.

Parameters:
- START_ADDR, 10'd1000, register-file address of the first data byte.
- CMD_ADDR, 10'd998, register-file address of the command high byte; the low byte is at CMD_ADDR+1.

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_rst  in  1  asynchronous, active-low reset.
- i_engine_en  in  1  start request, sampled in IDLE only.
- i_rnw  in  1  1 = read, 0 = write; latched at start.
- i_word_cnt  in  8  number of 16-bit data words; latched at start.
- i_tx_mode_done  in  1  serializer finished the current mode.
- i_rx_mode_done  in  1  deserializer finished the current mode.
- i_rx_pre  in  1  preamble bit value sampled by rx.
- i_rx_error  in  1  parity/CRC/token error from rx, valid with i_rx_mode_done.
- o_tx_en  out  1  serializer enable.
- o_tx_mode  out  3  000 PRE_ZERO, 001 PRE_ONE, 011 SER_BYTE, 010 CRC_TOKEN, 110 PAR_VALUE, 111 CRC_VALUE.
- o_rx_en  out  1  deserializer enable.
- o_rx_mode  out  4  0001 preamble, 0010 data, 0100 parity, 0101 token, 0110 CRC value.
- o_sdahand_pp_od  out  1  equals o_tx_en (push-pull when driving).
- o_regf_rd_en  out  1  register-file read enable.
- o_regf_wr_en  out  1  register-file write enable.
- o_regf_addr  out  10  register-file address.
- o_bitcnt_en  out  1  bit counter enable.
- o_bitcnt_reset  out  1  bit counter reset.
- o_engine_done  out  1  one-cycle completion pulse.
- o_engine_err  out  2  status: 00 ok, 01 NACK, 10 parity/CRC error, 11 target abort.

Behaviour:
- Reset and IDLE outputs:
  - Enables 0; o_tx_mode=000; o_rx_mode=0001.
  - o_regf_addr=START_ADDR; o_bitcnt_reset=1; o_engine_done=0; o_engine_err=00.
  - Internal word counter = 0.
  - Reset mid-transfer returns to IDLE immediately.
- Handshakes:
  - md = i_tx_mode_done | i_rx_mode_done.
  - A state advances on the clock edge where md=1; otherwise it holds.
  - Outputs are decoded from the current state only.
  - o_bitcnt_en=1 in every non-IDLE state.
- Start: IDLE with i_engine_en=1 latches i_rnw and i_word_cnt, clears o_engine_err, and goes to CMD_P1. i_engine_en is ignored outside IDLE.
- Command phase (tx, in order):
  - CMD_P1: PRE_ZERO.
  - CMD_P2: PRE_ONE.
  - CMD_B1: SER_BYTE, rd_en=1, addr=CMD_ADDR.
  - CMD_B2: SER_BYTE, rd_en=1, addr=CMD_ADDR+1.
  - CMD_PAR: PAR_VALUE.
- Write path:
  - After CMD_PAR, go to WR_P1 if count≠0, else CRC_P1.
  - WR_P1: tx PRE_ONE.
  - WR_P2: rx preamble. On md: i_rx_pre=1 → WR_B1; i_rx_pre=0 → target abort, err=11, go to FIN.
  - WR_B1 and WR_B2: tx SER_BYTE, rd_en=1, addr=data pointer.
  - WR_PAR: tx PAR_VALUE. On md: decrement count; go to WR_P1 if remaining≠0, else CRC_P1.
- Read path:
  - After CMD_PAR, go to RD_P1.
  - RD_P1: tx PRE_ONE.
  - RD_ACK: rx preamble. On md: i_rx_pre=0 → ACK → RD_B1; i_rx_pre=1 → NACK, err=01, go to FIN.
  - RD_B1 and RD_B2: rx data mode; wr_en pulses 1 cycle on md at the data pointer.
  - RD_PAR: rx parity. On md: i_rx_error=1 → err=10, FIN; else decrement count (saturating at 0) → RD_NP1.
  - RD_NP1: rx preamble. On md: i_rx_pre=1 → RD_ABT; i_rx_pre=0 → CRC_RX_P2.
  - RD_ABT: tx PRE_ONE if count≠0 (then RD_B1), else PRE_ZERO (then FIN).
  - i_word_cnt=0 on a read is treated as 1.
  - CRC_RX_P2 → CRC_RX_TOK → CRC_RX_VAL: rx modes 0001, 0101, 0110. i_rx_error=1 at any md → err=10, FIN; otherwise CRC_RX_VAL md → FIN.
- CRC transmit (write path):
  - CRC_P1: PRE_ZERO, with o_bitcnt_reset=1 on entry.
  - CRC_P2: PRE_ONE.
  - CRC_TOK: CRC_TOKEN.
  - CRC_VAL: CRC_VALUE; md → FIN.
- Data pointer:
  - Loaded with START_ADDR at start.
  - +1 on md in each WR_B1/WR_B2/RD_B1/RD_B2.
  - 10-bit wrap: 1023 → 0.
- FIN: o_engine_done=1 for exactly one cycle, then IDLE. o_engine_err holds until the next start.
- Simultaneous i_tx_mode_done and i_rx_mode_done: treated as a single md.

Test Plan:
- Write, i_word_cnt=2, target continues → tx mode sequence 000,001,011,011,110,001,(rx),011,011,110,001,(rx),011,011,110,000,001,010,111; rd_en at addrs 998,999,1000–1003; done pulse; err=00.
- Read, i_word_cnt=1, ACK, then target preamble 0 and CRC clean → wr_en at 1000,1001; done; err=00.
- Read with i_rx_pre=1 in RD_ACK → no rx data states entered; done 1 cycle after md; err=01.
- Write, i_word_cnt=3, target aborts in the second WR_P2 → exactly 2 words (4 bytes) fetched; done; err=11.
- Read, i_word_cnt=1, target sends a second data preamble (1) → RD_ABT drives PRE_ZERO; done; err=00; i_rx_error on RD_PAR in a rerun → err=10.
- Reset asserted during WR_B2 → all outputs at reset values; o_regf_addr=1000; no done pulse; next i_engine_en starts cleanly.
